// File: rtl/hilo_unit.sv
// HI/LO architectural registers plus a fixed-latency multiply sequencer that
// drives an external Booth multiplier and captures its product into HI/LO.
module hilo_unit #(
  parameter int unsigned MULT_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(MULT_LATENCY);

  localparam logic [2:0] OpMult = 3'd1;
  localparam logic [2:0] OpMthi = 3'd2;
  localparam logic [2:0] OpMtlo = 3'd3;
  localparam logic [2:0] OpMfhi = 3'd4;
  localparam logic [2:0] OpMflo = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StCapture
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       mult_a_q, mult_a_d;
  logic [31:0]       mult_b_q, mult_b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              accept;

  assign op_ready = (state_q == StIdle) && !flush;
  assign accept   = op_valid && op_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mult_a_d   = mult_a_q;
    mult_b_d   = mult_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpMult: begin
              mult_a_d = op_a;
              mult_b_d = op_b;
              state_d  = StStart;
            end
            OpMthi: hi_d = op_a;
            OpMtlo: lo_d = op_a;
            OpMfhi: begin
              rd_data_d  = hi_q;
              rd_valid_d = 1'b1;
            end
            OpMflo: begin
              rd_data_d  = lo_q;
              rd_valid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StStart: begin
        // WAIT then spans counts MULT_LATENCY-2 down to 0, i.e. MULT_LATENCY-1 cycles.
        cnt_d   = CntW'(MULT_LATENCY - 2);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCapture: begin
        hi_d    = mult_hi;
        lo_d    = mult_lo;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abandon an in-flight multiply; the stale product never reaches HI/LO.
    if (flush && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mult_a_q   <= mult_a_d;
      mult_b_q   <= mult_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign mult_start = (state_q == StStart);
  assign busy       = (state_q != StIdle);
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: transaction-level model with timestamps, a stub
// multiplier with exact latency, directed scenarios and randomized traffic.
module tb_hilo_unit;
  localparam int unsigned L = 32;

  logic        clk = 1'b0;
  logic        reset, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] op_a, op_b, mult_hi, mult_lo;
  logic        op_ready, mult_start, rd_valid, busy;
  logic [31:0] mult_a, mult_b, hi, lo, rd_data;

  always #5 clk = ~clk;

  hilo_unit #(.MULT_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op(op),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .mult_start(mult_start),
    .mult_a(mult_a), .mult_b(mult_b), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  int nvec = 0;
  int nerr = 0;
  int unsigned cyc = 0;

  // Model: an active multiply is described by its START cycle index only.
  logic [31:0] m_hi, m_lo, m_rd, m_a, m_b;
  logic        m_rdv, m_act, m_acc;
  int unsigned m_s;

  // Stub multiplier: product is valid only in the cycle it is due.
  int unsigned q_due[$];
  logic [63:0] q_prod[$];

  int          rdy_low, start_cnt;
  logic        last_ready;
  logic [31:0] sav_hi, sav_lo;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_rd = '0; m_a = '0; m_b = '0;
    m_rdv = 1'b0; m_act = 1'b0; m_acc = 1'b0; m_s = 0;
    q_due.delete();
    q_prod.delete();
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic v, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic fl);
    op_valid = v; op = o; op_a = a; op_b = b; flush = fl;
    while (q_due.size() > 0 && q_due[0] < cyc) begin
      void'(q_due.pop_front());
      void'(q_prod.pop_front());
    end
    if (q_due.size() > 0 && q_due[0] == cyc) {mult_hi, mult_lo} = q_prod[0];
    else {mult_hi, mult_lo} = {$urandom, $urandom};
    #3;
    chk("op_ready", op_ready, !m_act && !fl);
    chk("busy", busy, m_act);
    chk("mult_start", mult_start, m_act && (cyc == m_s));
    chk("mult_a", mult_a, m_a);
    chk("mult_b", mult_b, m_b);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("rd_data", rd_data, m_rd);
    chk("rd_valid", rd_valid, m_rdv);
    last_ready = op_ready;
    if (!op_ready) rdy_low++;
    if (mult_start) begin
      start_cnt++;
      q_due.push_back(cyc + L);
      q_prod.push_back(smul(mult_a, mult_b));
    end
    @(posedge clk);
    m_rdv = 1'b0;
    m_acc = 1'b0;
    if (m_act) begin
      if (fl) m_act = 1'b0;
      else if (cyc == m_s + L) begin
        {m_hi, m_lo} = smul(m_a, m_b);
        m_act = 1'b0;
      end
    end else if (v && !fl) begin
      m_acc = 1'b1;
      case (o)
        3'd1: begin m_a = a; m_b = b; m_act = 1'b1; m_s = cyc + 1; end
        3'd2: m_hi = a;
        3'd3: m_lo = a;
        3'd4: begin m_rd = m_hi; m_rdv = 1'b1; end
        3'd5: begin m_rd = m_lo; m_rdv = 1'b1; end
        default: ;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, '0, 1'b0);
  endtask

  logic        pv, pfl;
  logic [2:0]  po;
  logic [31:0] pa, pb;

  initial begin
    reset = 1'b0; flush = 1'b0; op_valid = 1'b0; op = '0; op_a = '0; op_b = '0;
    mult_hi = '0; mult_lo = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state.
    chk("rst_hi", hi, 32'h0);
    chk("rst_ready", op_ready, 1'b1);
    idle(2);

    // Signed multiply 7 * -3.
    step(1'b1, 3'd1, 32'd7, 32'hFFFF_FFFD, 1'b0);
    rdy_low = 0; start_cnt = 0;
    idle(L + 8);
    chk("mul_start_cnt", start_cnt, 1);
    chk("mul_ready_low", rdy_low, 33);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_lo", lo, 32'hFFFF_FFEB);

    // MFHI held through a multiply stall; accepted in A+34.
    step(1'b1, 3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b1, 3'd4, '0, '0, 1'b0);
    chk("stall_rdv", rd_valid, 1'b1);
    chk("stall_rd", rd_data, 32'h1);
    chk("stall_lo", lo, 32'h0);
    idle(1);

    // Register moves, back to back.
    step(1'b1, 3'd2, 32'h1234_5678, '0, 1'b0);
    step(1'b1, 3'd3, 32'hCAFE_BABE, '0, 1'b0);
    step(1'b1, 3'd4, '0, '0, 1'b0);
    chk("mv_mfhi", rd_data, 32'h1234_5678);
    chk("mv_mfhi_v", rd_valid, 1'b1);
    step(1'b1, 3'd5, '0, '0, 1'b0);
    chk("mv_mflo", rd_data, 32'hCAFE_BABE);
    idle(1);
    chk("mv_rdv_drop", rd_valid, 1'b0);

    // Flush in A+10 abandons the multiply.
    step(1'b1, 3'd2, 32'hAAAA_AAAA, '0, 1'b0);
    step(1'b1, 3'd3, 32'h5555_5555, '0, 1'b0);
    step(1'b1, 3'd1, 32'd3, 32'd5, 1'b0);
    idle(9);
    step(1'b0, 3'd0, '0, '0, 1'b1);
    flush = 1'b0;
    #1;
    chk("fl_ready", op_ready, 1'b1);
    chk("fl_hi", hi, 32'hAAAA_AAAA);
    chk("fl_lo", lo, 32'h5555_5555);
    idle(L + 4);
    step(1'b1, 3'd5, '0, '0, 1'b0);
    chk("fl_mflo", rd_data, 32'h5555_5555);
    idle(1);

    // Reserved code is accepted and does nothing.
    sav_hi = hi; sav_lo = lo;
    step(1'b1, 3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0);
    chk("res_ready", last_ready, 1'b1);
    chk("res_hi", hi, sav_hi);
    chk("res_lo", lo, sav_lo);
    chk("res_rdv", rd_valid, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    step(1'b1, 3'd1, 32'h1234, 32'h5678, 1'b0);
    idle(10);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_hi", hi, 32'h0);
    chk("ar_lo", lo, 32'h0);
    chk("ar_rd", rd_data, 32'h0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_start", mult_start, 1'b0);
    chk("ar_a", mult_a, 32'h0);
    chk("ar_b", mult_b, 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 3'd4, '0, '0, 1'b0);
    chk("ar_mfhi_v", rd_valid, 1'b1);
    chk("ar_mfhi", rd_data, 32'h0);

    // Randomized traffic; a request is held until the model accepts it.
    pv = 1'b0; po = '0; pa = '0; pb = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!pv || m_acc) begin
        pv = ($urandom_range(0, 3) != 0);
        po = 3'($urandom_range(0, 7));
        pa = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        pb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      end
      pfl = ($urandom_range(0, 15) == 0);
      step(pv, po, pa, pb, pfl);
    end
    idle(L + 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
